// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 5-stage pipeline.
//   DATA_W / REG_AW / CTRL_W : default datapath, register-number and control widths
//   CTRL_* : bit positions inside the control word
//            {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_REGDST   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;
endpackage

// File: rtl/id_bypass.sv
// id_bypass: combinational WB-to-ID operand bypass for one register-file read port.
// The register file is written at the same edge that ID/EX captures, so a
// write-back to the register being read must be forwarded here.
// Ports:
//   src_reg     : register number being read (rs or rt)
//   rf_data     : register-file read data for src_reg
//   wb_regwrite : write-back enable this cycle
//   wb_reg      : write-back destination
//   wb_data     : write-back value
//   op          : bypassed operand
// Build option: ID_EX_ZERO_REG_EN makes register 0 read as zero and never
// forward a write-back aimed at it.
module id_bypass #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src_reg,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op
);

  logic wb_hit;

`ifdef ID_EX_ZERO_REG_EN
  assign wb_hit = wb_regwrite && (wb_reg == src_reg) && (wb_reg != '0);

  always_comb begin
    op = rf_data;
    if (src_reg == '0)
      op = '0;
    else if (wb_hit)
      op = wb_data;
  end
`else
  assign wb_hit = wb_regwrite && (wb_reg == src_reg);

  always_comb begin
    op = rf_data;
    if (wb_hit)
      op = wb_data;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB-to-ID bypass and load-use
// hazard detection.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   ID_*                : decoded instruction (valid, control, rs/rt/rd, immediate)
//   Read_data_1/2       : register-file read data for rs/rt
//   WB_*                : write-back port (enable, destination, value)
//   Flush               : kill the instruction entering EX
//   Stall               : combinational; freeze PC and IF/ID
//   EX_*                : registered EX-stage copies, EX_Data_1/2 bypassed
// Build option: ID_EX_ZERO_REG_EN treats register 0 as hard-wired zero in the
// bypass and hazard logic.
module id_ex_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CTRL_W = cpu_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_Valid,
  input  logic [CTRL_W-1:0] ID_Control,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic [REG_AW-1:0] ID_rd,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [DATA_W-1:0] Read_data_1,
  input  logic [DATA_W-1:0] Read_data_2,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_Write_register,
  input  logic [DATA_W-1:0] WB_Write_data,
  input  logic              Flush,
  output logic              Stall,
  output logic              EX_Valid,
  output logic [CTRL_W-1:0] EX_Control,
  output logic [REG_AW-1:0] EX_rs,
  output logic [REG_AW-1:0] EX_rt,
  output logic [REG_AW-1:0] EX_rd,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [DATA_W-1:0] EX_Data_1,
  output logic [DATA_W-1:0] EX_Data_2
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] op1, op2;
  logic              rt_hit;

  id_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_1 (
    .src_reg     (ID_rs),
    .rf_data     (Read_data_1),
    .wb_regwrite (WB_RegWrite),
    .wb_reg      (WB_Write_register),
    .wb_data     (WB_Write_data),
    .op          (op1)
  );

  id_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_2 (
    .src_reg     (ID_rt),
    .rf_data     (Read_data_2),
    .wb_regwrite (WB_RegWrite),
    .wb_reg      (WB_Write_register),
    .wb_data     (WB_Write_data),
    .op          (op2)
  );

  // rt is compared even when the ID instruction does not read it.
`ifdef ID_EX_ZERO_REG_EN
  assign rt_hit = ((EX_rt == ID_rs) || (EX_rt == ID_rt)) && (EX_rt != '0);
`else
  assign rt_hit = (EX_rt == ID_rs) || (EX_rt == ID_rt);
`endif

  // Only registered EX state and ID inputs feed Stall; no WB inputs.
  assign Stall = ID_Valid && EX_Valid && EX_Control[CTRL_MEMREAD] && rt_hit && !Flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_Valid   <= 1'b0;
      EX_Control <= '0;
      EX_rs      <= '0;
      EX_rt      <= '0;
      EX_rd      <= '0;
      EX_Imm     <= '0;
      EX_Data_1  <= '0;
      EX_Data_2  <= '0;
    end else if (Flush || Stall) begin
      // Flush kills; Stall inserts a bubble while ID is held upstream.
      EX_Valid   <= 1'b0;
      EX_Control <= '0;
      EX_rs      <= '0;
      EX_rt      <= '0;
      EX_rd      <= '0;
      EX_Imm     <= '0;
      EX_Data_1  <= '0;
      EX_Data_2  <= '0;
    end else begin
      EX_Valid   <= ID_Valid;
      EX_Control <= ID_Valid ? ID_Control : '0;
      EX_rs      <= ID_rs;
      EX_rt      <= ID_rt;
      EX_rd      <= ID_rd;
      EX_Imm     <= ID_Imm;
      EX_Data_1  <= op1;
      EX_Data_2  <= op2;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Valid;
  logic [7:0]  ID_Control;
  logic [4:0]  ID_rs, ID_rt, ID_rd;
  logic [31:0] ID_Imm;
  logic [31:0] Read_data_1, Read_data_2;
  logic        WB_RegWrite;
  logic [4:0]  WB_Write_register;
  logic [31:0] WB_Write_data;
  logic        Flush;
  logic        Stall;
  logic        EX_Valid;
  logic [7:0]  EX_Control;
  logic [4:0]  EX_rs, EX_rt, EX_rd;
  logic [31:0] EX_Imm, EX_Data_1, EX_Data_2;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .ID_Valid(ID_Valid), .ID_Control(ID_Control),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd), .ID_Imm(ID_Imm),
    .Read_data_1(Read_data_1), .Read_data_2(Read_data_2),
    .WB_RegWrite(WB_RegWrite), .WB_Write_register(WB_Write_register),
    .WB_Write_data(WB_Write_data), .Flush(Flush), .Stall(Stall),
    .EX_Valid(EX_Valid), .EX_Control(EX_Control),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd), .EX_Imm(EX_Imm),
    .EX_Data_1(EX_Data_1), .EX_Data_2(EX_Data_2)
  );

  int tests = 0;
  int fails = 0;

  // Architectural register file as the bench sees it; drives Read_data.
  logic [31:0] rf [32];

  // Expected EX slot contents.
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_imm, m_d1, m_d2;
  logic        stall_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value a register will hold once this cycle's write-back lands.
  function automatic logic [31:0] arch_val(input logic [4:0] r);
`ifdef ID_EX_ZERO_REG_EN
    if (r == 5'd0) return 32'd0;
`endif
    if (WB_RegWrite && WB_Write_register == r) return WB_Write_data;
    return rf[r];
  endfunction

  // A valid ID instruction reading the register a valid EX load produces must wait.
  function automatic logic exp_stall();
    logic dep;
    dep = (m_rt == ID_rs) || (m_rt == ID_rt);
`ifdef ID_EX_ZERO_REG_EN
    if (m_rt == 5'd0) dep = 1'b0;
`endif
    return ID_Valid && m_valid && m_ctrl[5] && dep && !Flush;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_imm = '0; m_d1 = '0; m_d2 = '0;
  endtask

  task automatic check_ex(input string tag);
    check({tag, ".valid"}, 32'(EX_Valid),   32'(m_valid));
    check({tag, ".ctrl"},  32'(EX_Control), 32'(m_ctrl));
    check({tag, ".rs"},    32'(EX_rs),      32'(m_rs));
    check({tag, ".rt"},    32'(EX_rt),      32'(m_rt));
    check({tag, ".rd"},    32'(EX_rd),      32'(m_rd));
    check({tag, ".imm"},   EX_Imm, m_imm);
    check({tag, ".d1"},    EX_Data_1, m_d1);
    check({tag, ".d2"},    EX_Data_2, m_d2);
  endtask

  // One clock: present register-file data, check Stall, clock, check EX.
  task automatic step(input string tag);
    logic es;
    Read_data_1 = rf[ID_rs];
    Read_data_2 = rf[ID_rt];
    @(negedge clk);
    es = exp_stall();
    stall_seen = Stall;
    check({tag, ".stall"}, 32'(Stall), 32'(es));
    @(posedge clk);
    if (rst || Flush || es) model_clear();
    else begin
      m_valid = ID_Valid;
      m_ctrl  = ID_Valid ? ID_Control : 8'h00;
      m_rs = ID_rs; m_rt = ID_rt; m_rd = ID_rd; m_imm = ID_Imm;
      m_d1 = arch_val(ID_rs);
      m_d2 = arch_val(ID_rt);
    end
    if (WB_RegWrite) begin
`ifdef ID_EX_ZERO_REG_EN
      if (WB_Write_register != 5'd0) rf[WB_Write_register] = WB_Write_data;
`else
      rf[WB_Write_register] = WB_Write_data;
`endif
    end
    #1;
    check_ex(tag);
  endtask

  task automatic set_id(input logic v, input logic [7:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
    ID_Valid = v; ID_Control = c; ID_rs = rs; ID_rt = rt; ID_rd = rd; ID_Imm = imm;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    WB_RegWrite = we; WB_Write_register = r; WB_Write_data = d;
  endtask

  initial begin
    logic held;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rst = 1'b1;
    Flush = 1'b0;
    set_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    Read_data_1 = '0; Read_data_2 = '0;
    model_clear();
    #2;
    check("reset.stall", 32'(Stall), 32'd0);
    check_ex("reset");
    @(negedge clk);
    rst = 1'b0;

    // Plain capture.
    rf[3] = 32'h11; rf[4] = 32'h22;
    set_id(1'b1, 8'h8A, 5'd3, 5'd4, 5'd6, 32'hFFFF_FFF0);
    step("plain");
    check("plain.d1_const", EX_Data_1, 32'h11);
    check("plain.d2_const", EX_Data_2, 32'h22);
    check("plain.valid_const", 32'(EX_Valid), 32'd1);

    // Reset asserted mid-cycle with a valid EX slot.
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid.valid", 32'(EX_Valid), 32'd0);
    check("rst_mid.d1", EX_Data_1, 32'd0);
    check("rst_mid.ctrl", 32'(EX_Control), 32'd0);
    check("rst_mid.stall", 32'(Stall), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step("after_rst");
    check("after_rst.valid_const", 32'(EX_Valid), 32'd1);

    // Bypass to both operands.
    rf[3] = 32'h1234;
    set_id(1'b1, 8'h80, 5'd3, 5'd3, 5'd7, 32'd5);
    set_wb(1'b1, 5'd3, 32'hDEAD);
    step("bypass");
    check("bypass.d1_const", EX_Data_1, 32'hDEAD);
    check("bypass.d2_const", EX_Data_2, 32'hDEAD);
    set_wb(1'b0, 5'd0, 32'd0);

    // Invalid slot carries no control.
    set_id(1'b0, 8'hFF, 5'd1, 5'd2, 5'd3, 32'd9);
    step("invalid");
    check("invalid.ctrl_const", 32'(EX_Control), 32'd0);

    // Load-use: lw r5, then consumer of r5.
    set_id(1'b1, 8'hE0, 5'd1, 5'd5, 5'd0, 32'd4);
    step("lw");
    set_id(1'b1, 8'h82, 5'd5, 5'd2, 5'd8, 32'd0);
    set_wb(1'b1, 5'd5, 32'hBEEF);
    step("lu_bubble");
    check("lu_bubble.stall_const", 32'(stall_seen), 32'd1);
    check("lu_bubble.valid_const", 32'(EX_Valid), 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    step("lu_replay");
    check("lu_replay.stall_const", 32'(stall_seen), 32'd0);
    check("lu_replay.valid_const", 32'(EX_Valid), 32'd1);
    check("lu_replay.rs_const", 32'(EX_rs), 32'd5);
    check("lu_replay.d1_const", EX_Data_1, 32'hBEEF);

    // Flush during hazard.
    set_id(1'b1, 8'hE0, 5'd1, 5'd5, 5'd0, 32'd4);
    step("lw2");
    set_id(1'b1, 8'h82, 5'd5, 5'd2, 5'd8, 32'd3);
    Flush = 1'b1;
    step("flush_haz");
    check("flush_haz.stall_const", 32'(stall_seen), 32'd0);
    check("flush_haz.valid_const", 32'(EX_Valid), 32'd0);
    check("flush_haz.imm_const", EX_Imm, 32'd0);
    Flush = 1'b0;

    // Register 0 handling.
    rf[0] = 32'h99;
    set_id(1'b1, 8'h80, 5'd0, 5'd9, 5'd1, 32'd0);
    set_wb(1'b1, 5'd0, 32'h55);
    step("zero_reg");
`ifdef ID_EX_ZERO_REG_EN
    check("zero_reg.d1_const", EX_Data_1, 32'd0);
`else
    check("zero_reg.d1_const", EX_Data_1, 32'h55);
`endif
    set_wb(1'b0, 5'd0, 32'd0);

    // Randomized traffic; a stalled instruction is re-presented unchanged.
    held = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        ID_Valid   = ($urandom_range(0, 9) < 8);
        ID_Control = 8'($urandom);
        ID_Control[5] = ($urandom_range(0, 1) == 1);
        ID_rs = 5'($urandom_range(0, 7));
        ID_rt = 5'($urandom_range(0, 7));
        ID_rd = 5'($urandom_range(0, 7));
        ID_Imm = $urandom;
      end
      set_wb(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
      Flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) rf[0] = $urandom;
      step("rand");
      held = stall_seen;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the 5-stage pipelined CPU. It captures the two register-file operands, register numbers, immediate and control word from decode into EX-stage registers, and applies a WB-to-ID bypass because register-file writes land at the same clock edge. It also detects load-use hazards, inserting one bubble and stalling upstream, and obeys a branch flush from later stages.

## Interface
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register-number width
- CTRL_W, 8, control word width: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}, bit 7 down to 0
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ID_Valid  in  1  decode slot holds a real instruction
- ID_Control  in  CTRL_W  decoded control word
- ID_rs, ID_rt, ID_rd  in  REG_AW  register numbers
- ID_Imm  in  DATA_W  sign-extended immediate
- Read_data_1, Read_data_2  in  DATA_W  register-file read ports (rs, rt)
- WB_RegWrite  in  1  write-back enable this cycle
- WB_Write_register  in  REG_AW  write-back destination
- WB_Write_data  in  DATA_W  write-back value
- Flush  in  1  kill the instruction entering EX
- Stall  out  1  combinational; freeze PC and IF/ID
- EX_Valid  out  1  EX slot valid
- EX_Control, EX_rs, EX_rt, EX_rd, EX_Imm  out  per field  registered copies
- EX_Data_1, EX_Data_2  out  DATA_W  registered, bypassed operands

## Operation
- Bypass: Op1 = (WB_RegWrite && WB_Write_register == ID_rs) ? WB_Write_data : Read_data_1; Op2 is the same using ID_rt and Read_data_2. No width change; plain muxes.
- Hazard: Stall = ID_Valid && EX_Valid && EX_Control[MemRead] && (EX_rt == ID_rs || EX_rt == ID_rt) && !Flush. rt is compared even for instructions that do not read rt (conservative).
- Edge update priority (highest first):
  - Flush: all EX outputs cleared to 0.
  - Stall: bubble. EX_Valid = 0 and all other EX fields = 0. The ID instruction is held upstream and re-presented next cycle.
  - Otherwise: capture. EX_Valid = ID_Valid, EX_Data_1/2 = Op1/Op2, other fields copied.
- A capture with ID_Valid = 0 forces EX_Control to 0, so an invalid slot never carries RegWrite/MemWrite.
- There is no other state. The bubble is naturally one cycle because the following cycle EX_Valid = 0, which drops Stall.

## Timing
- Latency: 1 cycle, ID inputs to EX outputs.
- Stall is valid in the same cycle as its ID inputs and depends on registered EX state. There is no comb path from WB inputs to Stall.
- Reset: every output is 0 immediately on rst assertion, independent of clk. Stall is therefore 0 while in reset. First capture happens at the first edge after rst deasserts.
- Simultaneous Flush and Stall: Flush wins and Stall reads 0.
- Simultaneous hazard and WB bypass match: the bubble is taken, and the bypass is re-evaluated when the instruction is re-presented.
- WB write whose destination matches both rs and rt: both operands are bypassed.

## Configuration
- ID_EX_ZERO_REG_EN defined:
  - ID_rs/ID_rt == 0 yields operand 0 regardless of Read_data or the bypass.
  - The bypass is suppressed when WB_Write_register == 0.
  - The hazard check ignores EX_rt == 0.
- ID_EX_ZERO_REG_EN undefined: register 0 is an ordinary register for bypass and hazard logic.

## Structure
- The shared package cpu_pkg holds:
  - the CTRL_W constant and the control bit indices (CTRL_REGWRITE = 7 down to CTRL_ALUOP = 1:0);
  - DATA_W and REG_AW defaults.
- One sub-module, id_bypass, is the natural split: a combinational operand mux instantiated twice, once per operand. It contains the zero-register logic under the macro.

## Test plan
- Reset mid-run: assert rst with EX_Valid = 1 -> all outputs 0 before the next edge. After release, the first capture appears one edge later.
- Plain capture: rs = 3, rt = 4, Read_data_1 = 0x11, Read_data_2 = 0x22, ID_Valid = 1 -> next cycle EX_Data_1 = 0x11, EX_Data_2 = 0x22, EX_Valid = 1.
- Bypass: WB_RegWrite = 1, WB_Write_register = 3, WB_Write_data = 0xDEAD, ID_rs = ID_rt = 3 -> EX_Data_1 = EX_Data_2 = 0xDEAD.
- Load-use: EX holds lw with EX_rt = 5 and MemRead = 1, ID_rs = 5 -> Stall = 1 and EX_Valid = 0 next edge. The cycle after, Stall = 0 and the held instruction is captured.
- Flush during hazard: same as the load-use case plus Flush = 1 -> Stall = 0 and all EX outputs 0.
- Zero register (macro on): WB writes 0x55 to r0, ID_rs = 0, Read_data_1 = 0x99 -> EX_Data_1 = 0. With the macro off, EX_Data_1 = 0x55.
